mm_bridge_loader: RTL and testbench

//  Host-side companion of the Montgomery-multiplier top level; owns the second port of the shared bridge BRAM.

---
 rtl/mm_bridge_loader.sv | 184 ++++++++++++++++++
 tb/tb_mm_bridge_loader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_bridge_loader.sv
// ---------------------------------------------------------------------------
// mm_bridge_loader
//
// Host-side companion of the Montgomery multiplier. It owns the second port
// of the shared bridge BRAM. It loads one operand set from a 17-bit
// valid/ready stream into the BRAM layout that the multiplier reads, then
// pulses the multiplier start. After the multiplier reports done, it reads
// the s result sections back and streams them out, least significant first.
//
// BRAM layout (word index k):
//   0            p_prime_0
//   1 .. s       p[0..s-1]
//   s+1 .. 2s    a[0..s-1]   (result sections overwrite these)
//   2s+1 .. 3s   b[0..s-1]
//
// Ports:
//   clock_i      single clock
//   reset_i      asynchronous, active-high reset
//   s_data_i     operand word, LS section first
//   s_valid_i    operand word valid
//   s_ready_o    operand word accepted when s_valid_i & s_ready_o
//   m_data_o     result section, LS first
//   m_valid_o    result word valid
//   m_ready_i    downstream ready
//   m_last_o     high together with result section s-1
//   BRAM_addr_o  bridge BRAM address, zero-extended to 32 bits
//   BRAM_din_o   BRAM write data
//   BRAM_dout_i  BRAM read data, valid one cycle after an enabled read
//   BRAM_we_o    BRAM write enable
//   BRAM_en_o    BRAM enable
//   mm_start_o   one-cycle start pulse to the multiplier
//   mm_done_i    multiplier done, only looked at while waiting for it
//   busy_o       high whenever the loader is not idle
// ---------------------------------------------------------------------------
module mm_bridge_loader #(
  parameter int s        = 8,
  parameter int RES_BASE = s + 1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [16:0] s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [16:0] m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        m_last_o,
  output logic [31:0] BRAM_addr_o,
  output logic [16:0] BRAM_din_o,
  input  logic [16:0] BRAM_dout_i,
  output logic        BRAM_we_o,
  output logic        BRAM_en_o,
  output logic        mm_start_o,
  input  logic        mm_done_i,
  output logic        busy_o
);

  localparam int KW = $clog2(3 * s + 1);
  localparam int JW = $clog2(s);
  localparam int AW = $clog2(4 * s);

  localparam logic [KW-1:0] K_LAST   = KW'(3 * s);
  localparam logic [JW-1:0] J_LAST   = JW'(s - 1);
  localparam logic [AW-1:0] RES_ADDR = AW'(RES_BASE);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RD    = 3'd4;
  localparam logic [2:0] ST_RDW   = 3'd5;
  localparam logic [2:0] ST_SEND  = 3'd6;

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [KW-1:0] k_q;
  logic [JW-1:0] j_q;
  logic [16:0]   data_q;
  logic          armed_q;

  logic          in_load;
  logic          wr_fire;
  logic          m_fire;
  logic [AW-1:0] addr_local;

  // Ingress is open only while idle or loading. armed_q keeps s_ready_o low
  // while reset is asserted and until the first clock edge after it is
  // released, because the reset state is IDLE.
  assign in_load   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign s_ready_o = armed_q & in_load;
  assign wr_fire   = s_valid_i & s_ready_o;
  assign m_fire    = (state_q == ST_SEND) & m_ready_i;

  // Next-state logic. mm_done_i is only looked at in WAIT, so a done pulse
  // in any other state has no effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_fire) begin
          state_d = (k_q == K_LAST) ? ST_START : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (wr_fire && (k_q == K_LAST)) begin
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mm_done_i) begin
          state_d = ST_RD;
        end
      end
      ST_RD:  state_d = ST_RDW;
      ST_RDW: state_d = ST_SEND;
      ST_SEND: begin
        if (m_fire) begin
          state_d = (j_q == J_LAST) ? ST_IDLE : ST_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, word counters and the captured result word. The k
  // counter stops at 3s because that handshake hands over to START. Both
  // counters clear when the result stream finishes.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      j_q     <= '0;
      data_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      state_q <= state_d;

      if ((state_q == ST_SEND) && (state_d == ST_IDLE)) begin
        k_q <= '0;
      end else if (wr_fire && (k_q != K_LAST)) begin
        k_q <= k_q + 1'b1;
      end

      if (m_fire) begin
        if (j_q == J_LAST) begin
          j_q <= '0;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end

      // Read data from the RD cycle arrives during RDW.
      if (state_q == ST_RDW) begin
        data_q <= BRAM_dout_i;
      end
    end
  end

  // BRAM port. Writes are combinational from the ingress handshake, so each
  // word lands at address k in the same cycle it is accepted. The address
  // is forced to zero outside load and read cycles.
  always_comb begin
    addr_local = '0;
    if (wr_fire) begin
      addr_local = AW'(k_q);
    end else if (state_q == ST_RD) begin
      addr_local = RES_ADDR + AW'(j_q);
    end
  end

  assign BRAM_addr_o = {{(32 - AW){1'b0}}, addr_local};
  assign BRAM_din_o  = wr_fire ? s_data_i : 17'd0;
  assign BRAM_we_o   = wr_fire;
  assign BRAM_en_o   = wr_fire | (state_q == ST_RD);

  assign mm_start_o  = (state_q == ST_START);
  assign m_valid_o   = (state_q == ST_SEND);
  assign m_last_o    = (state_q == ST_SEND) && (j_q == J_LAST);
  assign m_data_o    = data_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mm_bridge_loader.sv
// ---------------------------------------------------------------------------
// tb_mm_bridge_loader
//
// Directed bench for mm_bridge_loader with s = 8. The bench contains a small
// BRAM model. That model also stands in for the multiplier: on the start
// pulse it writes 0x10000+j into result section j. A negedge monitor
// compares BRAM writes, BRAM reads and result words against queues that the
// stimulus fills while it drives inputs.
// ---------------------------------------------------------------------------
module tb_mm_bridge_loader;

  localparam int S = 8;
  localparam int NWORDS = 3 * S + 1;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [16:0] s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [16:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        m_last_o;
  logic [31:0] BRAM_addr_o;
  logic [16:0] BRAM_din_o;
  logic [16:0] bram_dout;
  logic        BRAM_we_o;
  logic        BRAM_en_o;
  logic        mm_start_o;
  logic        mm_done_i;
  logic        busy_o;

  mm_bridge_loader #(.s(S)) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_last_o    (m_last_o),
    .BRAM_addr_o (BRAM_addr_o),
    .BRAM_din_o  (BRAM_din_o),
    .BRAM_dout_i (bram_dout),
    .BRAM_we_o   (BRAM_we_o),
    .BRAM_en_o   (BRAM_en_o),
    .mm_start_o  (mm_start_o),
    .mm_done_i   (mm_done_i),
    .busy_o      (busy_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;
  int start_count = 0;
  int words_seen = 0;
  int reads_seen = 0;
  int word_base = 0;
  int read_base = 0;

  logic [48:0] wr_q [$];
  logic [31:0] rd_q [$];
  logic [17:0] res_q [$];
  logic [48:0] wr_e;
  logic [31:0] rd_e;
  logic [17:0] res_e;

  logic [16:0] mem [0:31];

  // BRAM model. The start pulse also stands in for the multiplier
  // depositing its result sections over operand a.
  always @(posedge clock_i) begin
    if (BRAM_en_o) begin
      if (BRAM_we_o) mem[BRAM_addr_o[4:0]] <= BRAM_din_o;
      else           bram_dout <= mem[BRAM_addr_o[4:0]];
    end
    if (mm_start_o) begin
      for (int j = 0; j < S; j++) mem[S + 1 + j] <= 17'h10000 + 17'(j);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard monitor, which samples on the falling edge.
  always @(negedge clock_i) begin
    if (!reset_i) begin
      if (mm_start_o) begin
        start_count++;
        checkOutput("start_bram_quiet", 32'({BRAM_en_o, BRAM_we_o}), 32'd0);
      end
      if (BRAM_en_o && BRAM_we_o) begin
        checkOutput("wr_pending", 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) begin
          wr_e = wr_q.pop_front();
          checkOutput("wr_addr", BRAM_addr_o, wr_e[48:17]);
          checkOutput("wr_data", 32'(BRAM_din_o), 32'(wr_e[16:0]));
        end
      end
      if (BRAM_en_o && !BRAM_we_o) begin
        reads_seen++;
        checkOutput("rd_pending", 32'(rd_q.size() > 0), 32'd1);
        if (rd_q.size() > 0) begin
          rd_e = rd_q.pop_front();
          checkOutput("rd_addr", BRAM_addr_o, rd_e);
        end
      end
      if (m_valid_o && m_ready_i) begin
        words_seen++;
        checkOutput("res_pending", 32'(res_q.size() > 0), 32'd1);
        if (res_q.size() > 0) begin
          res_e = res_q.pop_front();
          checkOutput("res_last_data", 32'({m_last_o, m_data_o}), 32'(res_e));
        end
      end
    end
  end

  // Assert reset in the middle of a cycle. Check that every output drops at
  // once, then release reset and check that the block is idle and ready.
  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    checkOutput("reset_outputs",
                32'({s_ready_o, m_valid_o, m_last_o, BRAM_we_o, BRAM_en_o,
                     mm_start_o, busy_o}), 32'd0);
    checkOutput("reset_m_data", 32'(m_data_o), 32'd0);
    checkOutput("reset_addr", BRAM_addr_o, 32'd0);
    checkOutput("reset_din", 32'(BRAM_din_o), 32'd0);
    wr_q.delete();
    rd_q.delete();
    res_q.delete();
    repeat (2) @(posedge clock_i);
    #1 reset_i = 1'b0;
    @(posedge clock_i); #1;
    @(negedge clock_i);
    checkOutput("post_reset_ready", 32'(s_ready_o), 32'd1);
    checkOutput("post_reset_busy", 32'(busy_o), 32'd0);
    @(posedge clock_i); #1;
  endtask

  // Stream one 25-word operand set 0x00001..0x00019. The gaps option adds
  // random idle cycles between words. The poke_done option raises mm_done_i
  // while word 10 is offered. The task ends in the second cycle after the
  // last handshake, which is the first WAIT cycle.
  task automatic applyStimulus(input bit gaps, input bit poke_done);
    int  sc0;
    int  n;
    int  g;
    bit  hs;
    sc0 = start_count;
    for (int i = 0; i < NWORDS; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 3);
        repeat (g) begin
          s_valid_i = 1'b0;
          s_data_i  = 17'h1ffff;
          mm_done_i = 1'b0;
          @(negedge clock_i);
          if (i > 0) checkOutput("busy_in_gap", 32'(busy_o), 32'd1);
          @(posedge clock_i); #1;
        end
      end
      wr_q.push_back({32'(i), 17'(i + 1)});
      s_valid_i = 1'b1;
      s_data_i  = 17'(i + 1);
      mm_done_i = poke_done && (i == 10);
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 50) begin
        @(negedge clock_i);
        hs = s_ready_o;
        @(posedge clock_i); #1;
        n++;
      end
      if (!hs) checkOutput("ingress_timeout", 32'(hs), 32'd1);
    end
    s_valid_i = 1'b0;
    s_data_i  = 17'd0;
    mm_done_i = 1'b0;
    @(negedge clock_i);
    checkOutput("start_pulse", 32'(mm_start_o), 32'd1);
    checkOutput("ready_in_start", 32'(s_ready_o), 32'd0);
    @(negedge clock_i);
    checkOutput("start_once", 32'(mm_start_o), 32'd0);
    checkOutput("start_count", 32'(start_count - sc0), 32'd1);
    checkOutput("writes_drained", 32'(wr_q.size()), 32'd0);
  endtask

  // Queue the expected reads and results, then pulse done in cycle D. Check
  // that m_valid_o first rises in cycle D+3.
  task automatic pulse_done(input bit ready_during, input bit ingress_junk);
    word_base = words_seen;
    read_base = reads_seen;
    for (int j = 0; j < S; j++) begin
      rd_q.push_back(32'(S + 1 + j));
      res_q.push_back({(j == S - 1), 17'h10000 + 17'(j)});
    end
    m_ready_i = ready_during;
    if (ingress_junk) begin
      s_valid_i = 1'b1;
      s_data_i  = 17'h1abcd;
    end
    @(posedge clock_i); #1;
    @(negedge clock_i);
    checkOutput("wait_bram_en", 32'(BRAM_en_o), 32'd0);
    checkOutput("wait_ready", 32'(s_ready_o), 32'd0);
    @(posedge clock_i); #1 mm_done_i = 1'b1;
    @(posedge clock_i); #1 mm_done_i = 1'b0;
    @(negedge clock_i);
    checkOutput("valid_d1", 32'(m_valid_o), 32'd0);
    @(negedge clock_i);
    checkOutput("valid_d2", 32'(m_valid_o), 32'd0);
    @(negedge clock_i);
    checkOutput("valid_d3", 32'(m_valid_o), 32'd1);
  endtask

  // Drain the result stream. A stall_word of 0 or more holds m_ready_i low
  // for 10 cycles once that word is presented. With done_in_send set, done
  // is also pulsed during the stall.
  task automatic read_out(input int stall_word, input bit done_in_send);
    int          n;
    int          r0;
    logic [16:0] held;
    if (stall_word >= 0) begin
      n = 0;
      while ((words_seen - word_base) != stall_word && n < 100) begin
        @(negedge clock_i); #1;
        n++;
      end
      checkOutput("reach_stall_word", 32'(words_seen - word_base), 32'(stall_word));
      @(posedge clock_i); #1 m_ready_i = 1'b0;
      n = 0;
      @(negedge clock_i);
      while (!m_valid_o && n < 10) begin
        @(negedge clock_i);
        n++;
      end
      held = m_data_o;
      r0   = reads_seen;
      checkOutput("stall_word_data", 32'(held), 32'h10000 + 32'(stall_word));
      for (int c = 0; c < 10; c++) begin
        mm_done_i = done_in_send && (c == 3);
        @(negedge clock_i);
        checkOutput("stall_valid", 32'(m_valid_o), 32'd1);
        checkOutput("stall_data", 32'(m_data_o), 32'(held));
      end
      mm_done_i = 1'b0;
      checkOutput("stall_no_read", 32'(reads_seen - r0), 32'd0);
      @(posedge clock_i); #1 m_ready_i = 1'b1;
    end
    n = 0;
    while (!(m_valid_o && m_last_o && m_ready_i) && n < 200) begin
      @(negedge clock_i);
      n++;
    end
    checkOutput("last_word_seen", 32'(m_valid_o && m_last_o && m_ready_i), 32'd1);
    s_valid_i = 1'b0;
    s_data_i  = 17'd0;
    @(negedge clock_i);
    checkOutput("idle_busy", 32'(busy_o), 32'd0);
    checkOutput("idle_valid", 32'(m_valid_o), 32'd0);
    checkOutput("words_sent", 32'(words_seen - word_base), 32'(S));
    checkOutput("reads_issued", 32'(reads_seen - read_base), 32'(S));
    checkOutput("res_drained", 32'(res_q.size()), 32'd0);
    @(posedge clock_i); #1;
  endtask

  initial begin
    int sc;
    reset_i   = 1'b1;
    s_data_i  = 17'd0;
    s_valid_i = 1'b0;
    m_ready_i = 1'b0;
    mm_done_i = 1'b0;
    @(posedge clock_i); #1;
    do_reset();

    $display("[TB] back-to-back load and full readout");
    applyStimulus(1'b0, 1'b0);
    pulse_done(1'b1, 1'b0);
    read_out(-1, 1'b0);

    $display("[TB] gapped load, readout stalled on word 3");
    applyStimulus(1'b1, 1'b0);
    pulse_done(1'b1, 1'b0);
    read_out(2, 1'b0);

    $display("[TB] stray done pulses and ingress while busy");
    applyStimulus(1'b0, 1'b1);
    pulse_done(1'b1, 1'b1);
    read_out(2, 1'b1);
    sc = start_count;
    mm_done_i = 1'b1;
    @(posedge clock_i); #1 mm_done_i = 1'b0;
    @(negedge clock_i);
    checkOutput("idle_done_busy", 32'(busy_o), 32'd0);
    checkOutput("idle_done_start", 32'(start_count - sc), 32'd0);
    @(posedge clock_i); #1;

    $display("[TB] reset during WAIT and during SEND");
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clock_i);
    #1;
    do_reset();
    applyStimulus(1'b0, 1'b0);
    pulse_done(1'b0, 1'b0);
    checkOutput("pre_reset_send", 32'(m_valid_o), 32'd1);
    @(posedge clock_i); #1;
    do_reset();
    m_ready_i = 1'b1;
    applyStimulus(1'b0, 1'b0);
    pulse_done(1'b1, 1'b0);
    read_out(-1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
